branch_resolve_unit: RTL and testbench

Front-end counterpart of the back-end branch/jalr resolution interface. Sits in pcGen and keeps a FIFO (branch history queue, BHQ) of the predicted direction and alternate PC for every in-flight conditional branch. It consumes takenBranch/jalr results from the back end, raises isMisPredict, and drives fetch redirect/stall. It holds state until the commit-side isFlush arrives.

---
 rtl/branch_resolve_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Front-end branch resolution block in pcGen. Keeps a branch history queue
//   (BHQ) of {predicted direction, not-predicted PC} for each in-flight
//   conditional branch. It pops the head on each back-end resolution and
//   flags a mispredict. It also sequences jalr stalls and drives the fetch
//   redirect and stall outputs.
//
//   Ports
//     CLK, RSTn                 clock, asynchronous active-low reset
//     bp_push/bp_taken/bp_resume_pc   fetch-side prediction push
//     bhq_full                  queue full (combinational from flops)
//     takenBranch(_vaild)       back-end resolution
//     pcGen_ready               resolution accept (combinational)
//     jalr_req/jalr_vaild/jalr_pc     jalr stall and target
//     isFlush                   commit flush, highest priority
//     isMisPredict              level, held until flush
//     redirect_vaild/redirect_pc      one-cycle redirect pulse and target
//     fetch_stall               fetch hold
//
//   Optional build macro BRU_PREDICT_STAT_EN adds the saturating counters
//   stat_resolve_cnt and stat_mispred_cnt. Only reset clears them.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int BHQ_AW = 3,
  parameter int PC_W   = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            bp_push,
  input  logic            bp_taken,
  input  logic [PC_W-1:0] bp_resume_pc,
  output logic            bhq_full,
  input  logic            takenBranch,
  input  logic            takenBranch_vaild,
  output logic            pcGen_ready,
  input  logic            jalr_req,
  input  logic            jalr_vaild,
  input  logic [PC_W-1:0] jalr_pc,
  input  logic            isFlush,
  output logic            isMisPredict,
  output logic            redirect_vaild,
  output logic [PC_W-1:0] redirect_pc,
  output logic            fetch_stall
`ifdef BRU_PREDICT_STAT_EN
  ,
  output logic [31:0]     stat_resolve_cnt,
  output logic [31:0]     stat_mispred_cnt
`endif
);

  localparam int DEPTH = 1 << BHQ_AW;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_JALR_WAIT = 2'd1;
  localparam logic [1:0] S_MISPRED   = 2'd2;

  logic [DEPTH-1:0]            taken_mem_q, taken_mem_d;
  logic [DEPTH-1:0][PC_W-1:0]  pc_mem_q, pc_mem_d;
  logic [BHQ_AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [BHQ_AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [BHQ_AW:0]             count_q, count_d;
  logic [1:0]                  state_q, state_d;
  logic                        mispred_q, mispred_d;
  logic                        redir_v_q, redir_v_d;
  logic [PC_W-1:0]             redir_pc_q, redir_pc_d;
  logic                        stall_q, stall_d;

  logic push_ok, accept, mismatch, jalr_done;

  assign bhq_full    = (count_q == (BHQ_AW+1)'(DEPTH));
  assign pcGen_ready = (count_q != '0) && (state_q != S_MISPRED) && !isFlush;
  assign accept      = takenBranch_vaild && pcGen_ready;
  assign push_ok     = bp_push && (state_q == S_IDLE) && !bhq_full && !isFlush;
  assign mismatch    = accept && (taken_mem_q[rd_ptr_q] != takenBranch);
  // A mispredict is always older than the stalled jalr, so it takes priority.
  assign jalr_done   = (state_q == S_JALR_WAIT) && jalr_vaild && !isFlush && !mismatch;

  always_comb begin
    taken_mem_d = taken_mem_q;
    pc_mem_d    = pc_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    mispred_d   = mispred_q;
    redir_v_d   = 1'b0;
    redir_pc_d  = redir_pc_q;

    if (isFlush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      state_d   = S_IDLE;
      mispred_d = 1'b0;
    end else begin
      if (push_ok) begin
        taken_mem_d[wr_ptr_q] = bp_taken;
        pc_mem_d[wr_ptr_q]    = bp_resume_pc;
        wr_ptr_d              = wr_ptr_q + BHQ_AW'(1);
      end
      if (accept)
        rd_ptr_d = rd_ptr_q + BHQ_AW'(1);
      count_d = count_q + (BHQ_AW+1)'(push_ok) - (BHQ_AW+1)'(accept);

      if (mismatch) begin
        mispred_d  = 1'b1;
        redir_v_d  = 1'b1;
        redir_pc_d = pc_mem_q[rd_ptr_q];
        state_d    = S_MISPRED;
      end else if (jalr_done) begin
        redir_v_d  = 1'b1;
        redir_pc_d = jalr_pc;
        state_d    = S_IDLE;
      end else if ((state_q == S_IDLE) && jalr_req) begin
        state_d = S_JALR_WAIT;
      end
    end
    // Stall is a registered view of the state being entered.
    stall_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      taken_mem_q <= '0;
      pc_mem_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      mispred_q   <= 1'b0;
      redir_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      stall_q     <= 1'b0;
    end else begin
      taken_mem_q <= taken_mem_d;
      pc_mem_q    <= pc_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mispred_q   <= mispred_d;
      redir_v_q   <= redir_v_d;
      redir_pc_q  <= redir_pc_d;
      stall_q     <= stall_d;
    end
  end

  assign isMisPredict   = mispred_q;
  assign redirect_vaild = redir_v_q;
  assign redirect_pc    = redir_pc_q;
  assign fetch_stall    = stall_q;

`ifdef BRU_PREDICT_STAT_EN
  logic [31:0] res_cnt_q, res_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (accept && (res_cnt_q != 32'hFFFF_FFFF))
      res_cnt_d = res_cnt_q + 32'd1;
    if (mismatch && (mis_cnt_q != 32'hFFFF_FFFF))
      mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign stat_resolve_cnt = res_cnt_q;
  assign stat_mispred_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Inputs change at posedge+1. The
// combinational outputs are checked in the same cycle. The registered
// outputs are checked after the following edge.
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        bp_push, bp_taken;
  logic [63:0] bp_resume_pc;
  logic        bhq_full;
  logic        takenBranch, takenBranch_vaild;
  logic        pcGen_ready;
  logic        jalr_req, jalr_vaild;
  logic [63:0] jalr_pc;
  logic        isFlush;
  logic        isMisPredict, redirect_vaild, fetch_stall;
  logic [63:0] redirect_pc;
`ifdef BRU_PREDICT_STAT_EN
  logic [31:0] stat_resolve_cnt, stat_mispred_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(.BHQ_AW(3), .PC_W(64)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .bp_push(bp_push), .bp_taken(bp_taken), .bp_resume_pc(bp_resume_pc),
    .bhq_full(bhq_full),
    .takenBranch(takenBranch), .takenBranch_vaild(takenBranch_vaild),
    .pcGen_ready(pcGen_ready),
    .jalr_req(jalr_req), .jalr_vaild(jalr_vaild), .jalr_pc(jalr_pc),
    .isFlush(isFlush),
    .isMisPredict(isMisPredict), .redirect_vaild(redirect_vaild),
    .redirect_pc(redirect_pc), .fetch_stall(fetch_stall)
`ifdef BRU_PREDICT_STAT_EN
    , .stat_resolve_cnt(stat_resolve_cnt), .stat_mispred_cnt(stat_mispred_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bp_push = 0; bp_taken = 0; bp_resume_pc = '0;
    takenBranch = 0; takenBranch_vaild = 0;
    jalr_req = 0; jalr_vaild = 0; jalr_pc = '0; isFlush = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_mis"}, isMisPredict, 0);
    chk({tag, "_rv"},  redirect_vaild, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
    chk({tag, "_stl"}, fetch_stall, 0);
    chk({tag, "_rdy"}, pcGen_ready, 0);
    chk({tag, "_ful"}, bhq_full, 0);
  endtask

  task automatic push(input logic t, input logic [63:0] pc);
    bp_push = 1; bp_taken = t; bp_resume_pc = pc;
    step();
    bp_push = 0;
  endtask

  task automatic flush();
    isFlush = 1;
    step();
    isFlush = 0;
  endtask

  logic [2:0] dirs;

  initial begin
    idle_in();
    RSTn = 0;
    #12;
    outs_zero("rst");
    step();
    RSTn = 1;
    step();
    takenBranch_vaild = 1;
    #1;
    chk("empty_rdy", pcGen_ready, 0);
    step();
    chk("empty_mis", isMisPredict, 0);
    takenBranch_vaild = 0;

    // three correctly predicted branches
    dirs = 3'b101;
    for (int i = 0; i < 3; i++) push(dirs[i], 64'h100 + 64'(i));
    for (int i = 0; i < 3; i++) begin
      takenBranch_vaild = 1; takenBranch = dirs[i];
      #1;
      chk("res3_rdy", pcGen_ready, 1);
      step();
    end
    takenBranch_vaild = 0;
    #1;
    chk("res3_mis", isMisPredict, 0);
    chk("res3_empty", pcGen_ready, 0);
    chk("res3_rv", redirect_vaild, 0);

    // mispredict and flush
    push(1, 64'h8000_0100);
    push(0, 64'h8000_0200);
    takenBranch_vaild = 1; takenBranch = 0;
    step();
    takenBranch_vaild = 0;
    chk("mp_mis", isMisPredict, 1);
    chk("mp_rv", redirect_vaild, 1);
    chk("mp_rpc", redirect_pc, 64'h8000_0100);
    chk("mp_stl", fetch_stall, 1);
    chk("mp_rdy", pcGen_ready, 0);
    bp_push = 1; bp_taken = 0; bp_resume_pc = 64'hDEAD;
    step();
    bp_push = 0;
    chk("mp_pulse", redirect_vaild, 0);
    chk("mp_hold", isMisPredict, 1);
    jalr_vaild = 1; jalr_pc = 64'h7777;
    step();
    jalr_vaild = 0;
    chk("mp_jalr_ign", redirect_vaild, 0);
    flush();
    chk("fl_mis", isMisPredict, 0);
    chk("fl_stl", fetch_stall, 0);
    chk("fl_rpc", redirect_pc, 64'h8000_0100);
    chk("fl_rdy", pcGen_ready, 0);

    // fill, overflow, push+pop while full
    for (int i = 0; i < 8; i++) push(1'(i), 64'h10 + 64'(i));
    chk("full", bhq_full, 1);
    push(1, 64'h99);
    chk("full9", bhq_full, 1);
    bp_push = 1; bp_taken = 1; bp_resume_pc = 64'hAA;
    takenBranch_vaild = 1; takenBranch = 0;
    step();
    bp_push = 0;
    chk("full_pp", bhq_full, 0);
    for (int i = 1; i < 8; i++) begin
      takenBranch = 1'(i);
      step();
    end
    takenBranch_vaild = 0;
    #1;
    chk("drain_mis", isMisPredict, 0);
    chk("drain_empty", pcGen_ready, 0);

    // 20 overlapped push/pop pairs across the pointer wrap; last pop mispredicts
    for (int k = 0; k <= 20; k++) begin
      bp_push = (k < 20); bp_taken = 1'(k); bp_resume_pc = 64'h1000 + 64'(k);
      takenBranch_vaild = (k > 0);
      takenBranch = (k == 20) ? 1'b0 : 1'(k - 1);
      if (k == 20) chk("wrap_mis", isMisPredict, 0);
      step();
    end
    bp_push = 0; takenBranch_vaild = 0;
    chk("wrap_mp", isMisPredict, 1);
    chk("wrap_rpc", redirect_pc, 64'h1000 + 64'd19);
    flush();

    // jalr stall and redirect
    jalr_req = 1;
    step();
    jalr_req = 0;
    for (int i = 0; i < 5; i++) begin
      bp_push = 1; bp_taken = 1; bp_resume_pc = 64'h55;
      chk("jw_stl", fetch_stall, 1);
      step();
    end
    bp_push = 0;
    chk("jw_nopush", pcGen_ready, 0);
    jalr_vaild = 1; jalr_pc = 64'h8000_2000;
    step();
    jalr_vaild = 0;
    chk("jr_rv", redirect_vaild, 1);
    chk("jr_rpc", redirect_pc, 64'h8000_2000);
    chk("jr_stl", fetch_stall, 0);
    step();
    chk("jr_pulse", redirect_vaild, 0);

    // push with jalr_req, then mispredict racing jalr_vaild
    bp_push = 1; bp_taken = 1; bp_resume_pc = 64'h3000; jalr_req = 1;
    step();
    bp_push = 0; jalr_req = 0;
    chk("pj_stl", fetch_stall, 1);
    chk("pj_rdy", pcGen_ready, 1);
    takenBranch_vaild = 1; takenBranch = 0;
    jalr_vaild = 1; jalr_pc = 64'h4000;
    step();
    takenBranch_vaild = 0; jalr_vaild = 0;
    chk("race_rpc", redirect_pc, 64'h3000);
    chk("race_mis", isMisPredict, 1);
    chk("race_stl", fetch_stall, 1);
    step();
    chk("race_hold", isMisPredict, 1);
    #2;
    RSTn = 0;
    #1;
    outs_zero("arst");
    step();
    RSTn = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
